// File: rtl/aes_pkg.sv
// -----------------------------------------------------------------------------
// aes_pkg
// Shared definitions for the AES mode engine: mode encodings, the controller
// state enum, the block width and the CTR counter increment helper.
// -----------------------------------------------------------------------------
package aes_pkg;

    localparam int BLK_W = 128;

    typedef enum logic [1:0] {
        MODE_OFB  = 2'd0,
        MODE_CFB  = 2'd1,
        MODE_CTR  = 2'd2,
        MODE_RSVD = 2'd3
    } mode_e;

    localparam logic DIR_ENC = 1'b0;
    localparam logic DIR_DEC = 1'b1;

    typedef enum logic [2:0] {
        UNKEYED,
        KEY_LAUNCH,
        KEY_WAIT,
        READY,
        BLK_LAUNCH,
        BLK_WAIT
    } state_e;

    // Increment only the low w bits of the counter block; the carry out of
    // that field is dropped, so all-ones wraps silently to zero.
    function automatic logic [BLK_W-1:0] ctr_inc(input logic [BLK_W-1:0] v,
                                                 input int unsigned     w);
        logic [BLK_W-1:0] mask;
        mask = (w >= 128) ? '1 : ((128'd1 << w) - 128'd1);
        return (v & ~mask) | ((v + 128'd1) & mask);
    endfunction

endpackage

// File: rtl/aes_mode_engine_if.sv
// -----------------------------------------------------------------------------
// aes_mode_engine_if
// Control, key-load and block-stream signals of the AES mode engine.
//   load/key/iv/mode/dir          : key and mode load request (master -> slave)
//   in_valid/in_ready/in_data     : input block handshake
//   out_valid/out_ready/out_data  : output block handshake
//   busy/mode_err/blk_cnt         : status (slave -> master)
// -----------------------------------------------------------------------------
interface aes_mode_engine_if #(
    parameter int CNT_WIDTH = 32
);
    logic                 load;
    logic [127:0]         key;
    logic [127:0]         iv;
    logic [1:0]           mode;
    logic                 dir;
    logic                 in_valid;
    logic                 in_ready;
    logic [127:0]         in_data;
    logic                 out_valid;
    logic                 out_ready;
    logic [127:0]         out_data;
    logic                 busy;
    logic                 mode_err;
    logic [CNT_WIDTH-1:0] blk_cnt;

    modport master (
        output load, key, iv, mode, dir, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, busy, mode_err, blk_cnt
    );

    modport slave (
        input  load, key, iv, mode, dir, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, busy, mode_err, blk_cnt
    );
endinterface

// File: rtl/aes_mode_engine_core.sv
// -----------------------------------------------------------------------------
// aes_mode_engine_core
// Iterative AES-128 encryptor, one round per clock, round keys generated on
// the fly so a key load completes immediately.
//   clk, rst : clock, asynchronous active-high reset
//   load     : latch key
//   start    : begin encrypting iBlock (ignored while a block is in flight)
//   key      : cipher key
//   iBlock   : plaintext block
//   oBlock   : ciphertext, valid once idle returns high after a start
//   idle     : no block in flight
// -----------------------------------------------------------------------------
module aes_mode_engine_core (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         start,
    input  logic [127:0] key,
    input  logic [127:0] iBlock,
    output logic [127:0] oBlock,
    output logic         idle
);

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = xt(aa);
        end
        return p;
    endfunction

    // S-box built from its definition: GF(2^8) inverse (x^254) followed by
    // the affine transform, instead of a 256-entry table.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] inv;
        logic [7:0] p;
        inv = 8'h01;
        p   = x;
        for (int i = 1; i < 8; i++) begin
            p   = gmul(p, p);
            inv = gmul(inv, p);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [127:0] next_rk(input logic [127:0] k, input logic [7:0] rcon);
        logic [31:0] w0, w1, w2, w3, t;
        {w0, w1, w2, w3} = k;
        t  = {sbox(w3[23:16]) ^ rcon, sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])};
        w0 = w0 ^ t;
        w1 = w1 ^ w0;
        w2 = w2 ^ w1;
        w3 = w3 ^ w2;
        return {w0, w1, w2, w3};
    endfunction

    // Byte i of the state is column i/4, row i%4; ShiftRows moves row r left
    // by r columns, so output byte i reads input byte (i + 4*r) mod 16.
    function automatic logic [127:0] aes_round(input logic [127:0] s,
                                               input logic [127:0] rk,
                                               input logic         last);
        logic [7:0]   b [16];
        logic [7:0]   a0, a1, a2, a3;
        logic [127:0] r;
        for (int i = 0; i < 16; i++)
            b[i] = sbox(s[127 - 8*((i + 4*(i % 4)) % 16) -: 8]);
        r = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = b[4*c];
            a1 = b[4*c+1];
            a2 = b[4*c+2];
            a3 = b[4*c+3];
            if (last)
                r[127 - 32*c -: 32] = {a0, a1, a2, a3};
            else
                r[127 - 32*c -: 32] = {xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3,
                                       a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
                                       a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3,
                                       xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3)};
        end
        return r ^ rk;
    endfunction

    logic [127:0] r_key;
    logic [127:0] r_state;
    logic [127:0] r_rk;
    logic [7:0]   r_rcon;
    logic [3:0]   r_round;
    logic         r_busy;
    logic [127:0] w_rk_next;

    assign w_rk_next = next_rk(r_rk, r_rcon);

    // NOTE: every register, including the wide datapath ones, is reset so the
    // block's output is deterministic right after rst; sequential state is
    // written with non-blocking assignments only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_key   <= '0;
            r_state <= '0;
            r_rk    <= '0;
            r_rcon  <= '0;
            r_round <= '0;
            r_busy  <= 1'b0;
        end else begin
            if (load) r_key <= key;
            if (start && !r_busy) begin
                r_state <= iBlock ^ r_key;
                r_rk    <= r_key;
                r_rcon  <= 8'h01;
                r_round <= 4'd1;
                r_busy  <= 1'b1;
            end else if (r_busy) begin
                r_state <= aes_round(r_state, w_rk_next, r_round == 4'd10);
                r_rk    <= w_rk_next;
                r_rcon  <= xt(r_rcon);
                r_round <= r_round + 4'd1;
                if (r_round == 4'd10) r_busy <= 1'b0;
            end
        end
    end

    assign oBlock = r_state;
    assign idle   = !r_busy;

endmodule

// File: rtl/aes_mode_engine.sv
// -----------------------------------------------------------------------------
// aes_mode_engine
// OFB / CFB / CTR block-cipher mode controller around one AES-128 core.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : aes_mode_engine_if.slave -- load request, input and output
//              block handshakes, busy / mode_err / blk_cnt status
// Parameters: CTR_WIDTH (8..128) width of the incrementing CTR field,
//             CNT_WIDTH width of the accepted-block counter.
// -----------------------------------------------------------------------------
module aes_mode_engine
    import aes_pkg::*;
#(
    parameter int CTR_WIDTH = 32,
    parameter int CNT_WIDTH = 32
) (
    input  logic              clk,
    input  logic              rst,
    aes_mode_engine_if.slave  bus
);

    state_e               r_state;
    mode_e                r_mode;
    logic                 r_dir;
    logic [127:0]         r_key;
    logic [127:0]         r_fb;
    logic [127:0]         r_din;
    logic [127:0]         r_out_data;
    logic                 r_out_valid;
    logic                 r_mode_err;
    logic                 r_busy;
    logic                 r_core_load;
    logic                 r_core_start;
    logic [CNT_WIDTH-1:0] r_blk_cnt;

    logic [127:0]         w_core_block;
    logic                 w_core_idle;
    logic                 w_in_ready;

    aes_mode_engine_core core (
        .clk    (clk),
        .rst    (rst),
        .load   (r_core_load),
        .start  (r_core_start),
        .key    (r_key),
        .iBlock (r_fb),
        .oBlock (w_core_block),
        .idle   (w_core_idle)
    );

    // A pending output blocks new input, and a load in the same cycle wins.
    assign w_in_ready = (r_state == READY) && !r_out_valid && !bus.load;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= UNKEYED;
            r_mode       <= MODE_OFB;
            r_dir        <= DIR_ENC;
            r_key        <= '0;
            r_fb         <= '0;
            r_din        <= '0;
            r_out_data   <= '0;
            r_out_valid  <= 1'b0;
            r_mode_err   <= 1'b0;
            r_busy       <= 1'b0;
            r_core_load  <= 1'b0;
            r_core_start <= 1'b0;
            r_blk_cnt    <= '0;
        end else begin
            r_core_load  <= 1'b0;
            r_core_start <= 1'b0;
            if (r_out_valid && bus.out_ready) r_out_valid <= 1'b0;

            case (r_state)
                UNKEYED, READY: begin
                    if (bus.load) begin
                        if (mode_e'(bus.mode) == MODE_RSVD) begin
                            r_mode_err <= 1'b1;
                            r_state    <= UNKEYED;
                        end else begin
                            r_key       <= bus.key;
                            r_fb        <= bus.iv;
                            r_mode      <= mode_e'(bus.mode);
                            r_dir       <= bus.dir;
                            r_blk_cnt   <= '0;
                            r_core_load <= 1'b1;
                            r_busy      <= 1'b1;
                            r_state     <= KEY_LAUNCH;
                        end
                    end else if (bus.in_valid && w_in_ready) begin
                        r_din        <= bus.in_data;
                        r_blk_cnt    <= r_blk_cnt + CNT_WIDTH'(1);
                        r_core_start <= 1'b1;
                        r_busy       <= 1'b1;
                        r_state      <= BLK_LAUNCH;
                    end
                end
                KEY_LAUNCH: r_state <= KEY_WAIT;
                KEY_WAIT: begin
                    if (w_core_idle) begin
                        r_busy  <= 1'b0;
                        r_state <= READY;
                    end
                end
                BLK_LAUNCH: r_state <= BLK_WAIT;
                BLK_WAIT: begin
                    if (w_core_idle) begin
                        r_out_data  <= w_core_block ^ r_din;
                        r_out_valid <= 1'b1;
                        case (r_mode)
                            MODE_OFB: r_fb <= w_core_block;
                            MODE_CFB: r_fb <= (r_dir == DIR_DEC) ? r_din
                                                                  : (w_core_block ^ r_din);
                            MODE_CTR: r_fb <= ctr_inc(r_fb, CTR_WIDTH);
                            default:  r_fb <= r_fb;
                        endcase
                        r_busy  <= 1'b0;
                        r_state <= READY;
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= UNKEYED;
                end
            endcase
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;
    assign bus.busy      = r_busy;
    assign bus.mode_err  = r_mode_err;
    assign bus.blk_cnt   = r_blk_cnt;

endmodule

// File: tb/tb_aes_mode_engine.sv
// -----------------------------------------------------------------------------
// tb_aes_mode_engine
// Directed bench for aes_mode_engine: OFB, CFB encrypt/decrypt, CTR with an
// 8-bit counter field, output backpressure, load with a pending output,
// reset during a block and the reserved-mode error.
// -----------------------------------------------------------------------------
module tb_aes_mode_engine;
    import aes_pkg::*;

    localparam logic [127:0] K      = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] IV     = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] P1     = 128'h6bc1bee22e409f96e93d7e117393172a;
    localparam logic [127:0] P2     = 128'hae2d8a571e03ac9c9eb76fac45af8e51;
    localparam logic [127:0] OFB1   = 128'h3b3fd92eb72dad20333449f8e83cfb4a;
    localparam logic [127:0] OFB2   = 128'h7789508d16918f03f53c52dac54ed825;
    localparam logic [127:0] CFB1   = 128'h3b3fd92eb72dad20333449f8e83cfb4a;
    localparam logic [127:0] CFB2   = 128'hc8a64537a0b3a93fcde3cdad9f1ce58b;
    localparam logic [127:0] CTR_IV = 128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdfeff;
    localparam logic [127:0] CTR_C1 = 128'h874d6191b620e3261bef6864990db6ce;
    localparam logic [127:0] CTR_WR = 128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdfe00;
    localparam int           LIMIT  = 200;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    aes_mode_engine_if #(.CNT_WIDTH(32)) bus ();

    aes_mode_engine #(.CTR_WIDTH(8), .CNT_WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int           checks = 0;
    int           errors = 0;
    logic [127:0] sb [$];
    logic [127:0] got;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (bus.busy && n < LIMIT) begin step(); n++; end
        checks++;
        assert (n < LIMIT) else begin
            errors++;
            $error("FAIL %s busy timeout observed=%0d expected<%0d", tag, n, LIMIT);
        end
    endtask

    task automatic do_load(input logic [127:0] k, input logic [127:0] v,
                           input logic [1:0] m, input logic d);
        bus.load = 1'b1; bus.key = k; bus.iv = v; bus.mode = m; bus.dir = d;
        step();
        bus.load = 1'b0;
        if (m != 2'd3) wait_idle("load");
    endtask

    task automatic send(input string tag, input logic [127:0] din);
        int n = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = din;
        while (!bus.in_ready && n < LIMIT) begin step(); n++; end
        checks++;
        assert (n < LIMIT) else begin
            errors++;
            $error("FAIL %s in_ready timeout observed=%0d expected<%0d", tag, n, LIMIT);
        end
        step();
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_out(input string tag, output logic [127:0] d);
        int n = 0;
        while (!bus.out_valid && n < LIMIT) begin step(); n++; end
        checks++;
        assert (n < LIMIT) else begin
            errors++;
            $error("FAIL %s out_valid timeout observed=%0d expected<%0d", tag, n, LIMIT);
        end
        d = bus.out_data;
    endtask

    // Pops the next scoreboard entry against the output and completes the
    // output handshake (out_ready must already be high).
    task automatic receive(input string tag);
        logic [127:0] d;
        logic [127:0] exp;
        wait_out(tag, d);
        exp = (sb.size() > 0) ? sb.pop_front() : ~d;
        check(tag, d, exp);
        step();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        bus.load = 1'b0; bus.key = '0; bus.iv = '0; bus.mode = '0; bus.dir = 1'b0;
        bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b1;

        // Reset state
        repeat (3) step();
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_in_ready",  bus.in_ready,  0);
        check("rst_busy",      bus.busy,      0);
        check("rst_mode_err",  bus.mode_err,  0);
        check("rst_blk_cnt",   bus.blk_cnt,   0);
        check("rst_out_data",  bus.out_data,  0);
        rst = 1'b0;
        step();
        check("unkeyed_in_ready", bus.in_ready, 0);

        // OFB
        do_load(K, IV, 2'd0, 1'b0);
        check("ofb_blk_cnt0", bus.blk_cnt, 0);
        check("ofb_in_ready", bus.in_ready, 1);
        sb.push_back(OFB1); send("ofb_b1", P1); receive("ofb_b1");
        sb.push_back(OFB2); send("ofb_b2", P2); receive("ofb_b2");
        check("ofb_blk_cnt2", bus.blk_cnt, 2);

        // CFB encrypt then decrypt
        do_load(K, IV, 2'd1, 1'b0);
        check("cfbe_blk_cnt0", bus.blk_cnt, 0);
        sb.push_back(CFB1); send("cfbe_b1", P1); receive("cfbe_b1");
        sb.push_back(CFB2); send("cfbe_b2", P2); receive("cfbe_b2");
        do_load(K, IV, 2'd1, 1'b1);
        sb.push_back(P1); send("cfbd_b1", CFB1); receive("cfbd_b1");
        sb.push_back(P2); send("cfbd_b2", CFB2); receive("cfbd_b2");
        check("cfbd_blk_cnt2", bus.blk_cnt, 2);

        // CTR with an 8-bit counter field: the second block must use ...fe00,
        // which a fresh load of ...fe00 reproduces for an all-zero input.
        do_load(K, CTR_IV, 2'd2, 1'b0);
        sb.push_back(CTR_C1); send("ctr_b1", P1); receive("ctr_b1");
        send("ctr_b2", '0);
        wait_out("ctr_b2", got);
        step();
        do_load(K, CTR_WR, 2'd2, 1'b0);
        sb.push_back(got); send("ctr_wrap", '0); receive("ctr_wrap");

        // Backpressure: output held for 20 cycles, next block waits
        do_load(K, IV, 2'd0, 1'b0);
        bus.out_ready = 1'b0;
        sb.push_back(OFB1); send("bp_b1", P1);
        wait_out("bp_b1", got);
        bus.in_valid = 1'b1; bus.in_data = P2;
        for (int i = 0; i < 20; i++) begin
            step();
            check("bp_out_data",  bus.out_data,  OFB1);
            check("bp_out_valid", bus.out_valid, 1);
            check("bp_in_ready",  bus.in_ready,  0);
        end
        check("bp_blk_cnt1", bus.blk_cnt, 1);
        bus.out_ready = 1'b1;
        receive("bp_b1");
        sb.push_back(OFB2); send("bp_b2", P2); receive("bp_b2");
        check("bp_blk_cnt2", bus.blk_cnt, 2);

        // Load while an output is pending keeps the output; new IV restarts
        do_load(K, IV, 2'd0, 1'b0);
        bus.out_ready = 1'b0;
        sb.push_back(OFB1); send("pend_b1", P1);
        wait_out("pend_b1", got);
        do_load(K, IV, 2'd0, 1'b0);
        check("pend_out_valid", bus.out_valid, 1);
        check("pend_out_data",  bus.out_data,  OFB1);
        check("pend_blk_cnt0",  bus.blk_cnt,   0);
        bus.out_ready = 1'b1;
        receive("pend_b1");
        sb.push_back(OFB1); send("reload_b1", P1); receive("reload_b1");

        // Reset during BLK_WAIT: outputs clear at once, no output follows
        send("rstblk", P2);
        step(); step();
        check("rstblk_busy", bus.busy, 1);
        rst = 1'b1;
        #1;
        check("rstblk_out_valid", bus.out_valid, 0);
        check("rstblk_out_data",  bus.out_data,  0);
        check("rstblk_busy0",     bus.busy,      0);
        check("rstblk_blk_cnt",   bus.blk_cnt,   0);
        check("rstblk_in_ready",  bus.in_ready,  0);
        step();
        rst = 1'b0;
        for (int i = 0; i < 30; i++) begin
            step();
            check("rstblk_no_out", bus.out_valid, 0);
        end
        check("rstblk_unkeyed", bus.in_ready, 0);
        check("rstblk_mode_err", bus.mode_err, 0);

        // Reserved mode
        do_load(K, IV, 2'd3, 1'b0);
        step();
        check("rsvd_mode_err", bus.mode_err, 1);
        check("rsvd_in_ready", bus.in_ready, 0);
        check("rsvd_busy",     bus.busy,     0);
        do_load(K, IV, 2'd0, 1'b0);
        check("rsvd_sticky",    bus.mode_err, 1);
        check("rsvd_keyed_rdy", bus.in_ready, 1);
        do_load(K, IV, 2'd3, 1'b0);
        for (int i = 0; i < 5; i++) begin
            step();
            check("rsvd_ready_drop", bus.in_ready, 0);
        end
        check("rsvd_mode_err2", bus.mode_err, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/aes_mode_engine.md
AES_MODE_ENGINE -- requirements
Module: aes_mode_engine

Interface
REQ-001 The block SHALL take parameter CTR_WIDTH, default 32, giving the width of the incrementing low field of the counter in CTR mode, legal range 8..128.
REQ-002 The block SHALL take parameter CNT_WIDTH, default 32, giving the width of the processed-block counter.
REQ-003 clk  in  1  clock; all state updates on the rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-high.
REQ-005 load  in  1  one-cycle request to latch key, iv, mode and dir and start key expansion.
REQ-006 key, iv  in  128 each  AES-128 key and initial feedback value, sampled only on an accepted load.
REQ-007 mode  in  2  mode select: 0=OFB, 1=CFB, 2=CTR, 3=reserved.
REQ-008 dir  in  1  CFB direction: 0=encrypt, 1=decrypt; ignored in OFB and CTR.
REQ-009 in_valid/in_ready, in_data  in/out/in  1/1/128  input block handshake.
REQ-010 out_valid/out_ready, out_data  out/in/out  1/1/128  output block handshake.
REQ-011 busy  out  1  high in any state other than READY or UNKEYED.
REQ-012 mode_err  out  1  sticky; set when a load arrives with mode=3.
REQ-013 blk_cnt  out  CNT_WIDTH  number of blocks accepted since the last accepted load.

Function
REQ-014 The FSM SHALL have exactly these states: UNKEYED, KEY_LAUNCH, KEY_WAIT, READY, BLK_LAUNCH, BLK_WAIT.
REQ-015 A load SHALL be accepted only in UNKEYED or READY; load in any other state SHALL be ignored.
REQ-016 An accepted load with mode 0..2 SHALL latch key, iv, mode and dir, clear blk_cnt, and go to KEY_LAUNCH.
REQ-017 An accepted load with mode=3 SHALL set mode_err, leave all other state unchanged, and go to UNKEYED.
REQ-018 In KEY_LAUNCH the block SHALL drive core load for one cycle and then move to KEY_WAIT.
REQ-019 KEY_WAIT SHALL go to READY on the first cycle the core reports idle.
REQ-020 in_ready SHALL equal (state==READY) && !out_valid && !load.
- Load beats a simultaneous in_valid.
REQ-021 A handshake (in_valid && in_ready) SHALL:
- capture in_data,
- increment blk_cnt (modulo 2^CNT_WIDTH),
- go to BLK_LAUNCH.
REQ-022 BLK_LAUNCH SHALL pulse core start for one cycle with the feedback register as the core input block, then go to BLK_WAIT.
REQ-023 BLK_WAIT SHALL exit on core idle and, in that same edge, load out_data = E(fb) XOR captured in_data, set out_valid, and return to READY.
REQ-024 Feedback update on completion:
- OFB: fb <= E(fb).
- CFB encrypt: fb <= out_data.
- CFB decrypt: fb <= captured in_data.
- CTR: fb[CTR_WIDTH-1:0] increments modulo 2^CTR_WIDTH; the upper bits stay unchanged.
REQ-025 out_valid SHALL hold out_data stable until out_ready; it SHALL clear on the handshake edge.
- Minimum block latency is in-handshake to out_valid = 2 cycles + core latency.
REQ-026 A load accepted while out_valid is high SHALL NOT drop the pending output.
REQ-027 The CTR counter wrap from all-ones to zero SHALL be silent, with no flag.

Reset
REQ-028 rst SHALL force the following, regardless of the current state:
- state=UNKEYED,
- fb, key register, captured input, out_data, blk_cnt = 0,
- out_valid, mode_err, busy = 0,
- in_ready = 0.
REQ-029 A block in flight at reset SHALL be discarded; no out_valid SHALL follow reset.

Structure
REQ-030 Mode encodings, the state enum and the CTR increment function SHALL live in the shared package aes_pkg.
REQ-031 The block SHALL instantiate exactly one AES core sub-module, core, using ports clk, rst, load, start, key, iBlock, oBlock, idle.

Verification
REQ-032 Test vectors for the scenarios below:
- K = 2b7e151628aed2a6abf7158809cf4f3c
- IV = 000102030405060708090a0b0c0d0e0f
- P1 = 6bc1bee22e409f96e93d7e117393172a
- P2 = ae2d8a571e03ac9c9eb76fac45af8e51
REQ-033 OFB: load K, IV, then P1, P2 -> 3b3fd92eb72dad20333449f8e83cfb4a, 7789508d16918f03f53c52dac54ed825; blk_cnt=2.
REQ-034 CFB encrypt then CFB decrypt: P1, P2 -> 3b3fd92eb72dad20333449f8e83cfb4a, c8a64537a0b3a93fcde3cdad9f1ce58b; reloading with dir=1 and feeding those ciphertexts -> P1, P2.
REQ-035 CTR: IV=f0f1f2f3f4f5f6f7f8f9fafbfcfdfeff, P1 -> 874d6191b620e3261bef6864990db6ce.
- With CTR_WIDTH=8, a second block uses counter ...feff+1 wrapping to ...fe00.
REQ-036 Backpressure: hold out_ready=0 for 20 cycles -> out_data stable, in_ready=0; release -> next block is accepted.
REQ-037 Reset and errors:
- Assert rst during BLK_WAIT -> all outputs zero, state UNKEYED, no out_valid.
- load with mode=3 -> mode_err=1, in_ready stays 0.
